// File: rtl/arith_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package arith_div_pkg;

    localparam int DIV_DW    = 16;
    localparam int DIV_CNT_W = $clog2(2 * DIV_DW);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    typedef logic [2*DIV_DW-1:0] dividend_t;
    typedef logic [DIV_DW-1:0]   divisor_t;
    typedef logic [DIV_DW:0]     prem_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor,
// and keep the difference only when it is non-negative.
module div_step
    import arith_div_pkg::*;
#(
    parameter int W = DIV_DW
)
(
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0]   shifted;
    logic [W-1:0] diff;

    // rem_in is always below the divisor, so a successful difference fits back in W bits.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted[W-1:0] - divisor;
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? diff : shifted[W-1:0];
    end

endmodule

// File: rtl/seq_divider_32by16.sv
// Iterative 2W-by-W unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes on both sides and one operation in flight.
module seq_divider_32by16
    import arith_div_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DW
)
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0]   divisor,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0]   remainder,
    output logic                    div_by_zero
);

    localparam int QW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(QW);

    div_state_t            state;
    div_state_t            state_next;
    logic [CW-1:0]         count;
    logic [QW-1:0]         work;
    logic [DATA_WIDTH-1:0] dsr;
    logic [DATA_WIDTH-1:0] prem;
    logic [DATA_WIDTH-1:0] step_rem;
    logic                  step_q;
    logic                  accept;

    assign accept = in_valid && in_ready;

    div_step #(.W(DATA_WIDTH)) u_step (
        .rem_in  (prem),
        .bit_in  (work[QW-1]),
        .divisor (dsr),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = (divisor == '0) ? DONE : CALC;
            CALC:    if (count == '0) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // The dividend register doubles as the quotient accumulator: each step shifts out
    // one dividend MSB and shifts in one quotient bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count       <= '0;
            work        <= '0;
            dsr         <= '0;
            prem        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                work        <= dividend;
                dsr         <= divisor;
                prem        <= '0;
                count       <= CW'(QW - 1);
                div_by_zero <= (divisor == '0);
                if (divisor == '0) begin
                    quotient  <= '1;
                    remainder <= dividend[DATA_WIDTH-1:0];
                end
            end else if (state == CALC) begin
                prem  <= step_rem;
                work  <= {work[QW-2:0], step_q};
                count <= count - 1'b1;
                if (count == '0) begin
                    quotient  <= {work[QW-2:0], step_q};
                    remainder <= step_rem;
                end
            end
        end
    end

endmodule
